// File: rtl/backprop_accum.sv
// Back-propagation accumulator: joins one delta vector with its weight matrix and
// produces S[p] = sum_c sat(delta[c]*w[p][c]) for all parents, one child per cycle.

module backprop_accum_mac #(
    parameter int WV = 4,
    parameter int WO = 7
) (
    input  logic [WV-1:0] delta_i,
    input  logic [WV-1:0] w_i,
    output logic [WO-1:0] term_o
);
    localparam logic signed [2*WV-1:0] MAXV = {{(WV+1){1'b0}}, {(WV-1){1'b1}}};

    logic signed [2*WV-1:0] d_x, w_x, prod, scaled;
    logic        [WV-1:0]   sat;

    always_comb begin
        d_x    = (2*WV)'($signed(delta_i));
        w_x    = (2*WV)'($signed(w_i));
        prod   = d_x * w_x;
        // Q1.x * Q1.x -> Q2.x; only (-1)*(-1) exceeds the representable range
        scaled = prod >>> (WV-1);
        if (scaled > MAXV) sat = MAXV[WV-1:0];
        else               sat = scaled[WV-1:0];
        term_o = WO'($signed(sat));
    end
endmodule

module backprop_accum #(
    parameter int NP = 5,
    parameter int NC = 6,
    parameter int WV = 4,
    localparam int WO = $clog2(NC) + WV
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iValid_AM_Delta,
    output logic                 oReady_AM_Delta,
    input  logic [NC*WV-1:0]     iData_AM_Delta,
    input  logic                 iValid_AM_Weight,
    output logic                 oReady_AM_Weight,
    input  logic [NP*NC*WV-1:0]  iData_AM_Weight,
    output logic                 oValid_BM_Accum,
    input  logic                 iReady_BM_Accum,
    output logic [NP*WO-1:0]     oData_BM_Accum
);
    localparam int CW = (NC > 1) ? $clog2(NC) : 1;

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    state_t                 state_q, state_d;
    logic [NC*WV-1:0]       delta_q;
    logic [NP*NC*WV-1:0]    w_q;
    logic [CW-1:0]          cnt_q;
    logic [NP-1:0][WO-1:0]  acc_q;
    logic [NP-1:0][WO-1:0]  term, term_q;
    logic                   term_vld_q;
    logic                   valid_q;
    logic                   accept;
    logic                   cnt_last;

    assign cnt_last        = (cnt_q == CW'(NC-1));
    assign oValid_BM_Accum = valid_q;
    assign oData_BM_Accum  = acc_q;

    genvar p;
    generate
        for (p = 0; p < NP; p++) begin : g_lane
            logic [WV-1:0] w_sel;
            assign w_sel = w_q[(p*NC + int'(cnt_q))*WV +: WV];
            backprop_accum_mac #(.WV(WV), .WO(WO)) u_mac (
                .delta_i (delta_q[int'(cnt_q)*WV +: WV]),
                .w_i     (w_sel),
                .term_o  (term[p])
            );
        end
    endgenerate

    always_ff @(posedge iCLK) begin
        if (iRST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        oReady_AM_Delta  = 1'b0;
        oReady_AM_Weight = 1'b0;
        accept           = 1'b0;
        case (state_q)
            IDLE: begin
                // join: each side is ready only when the other side is valid
                oReady_AM_Delta  = iValid_AM_Weight & ~iRST;
                oReady_AM_Weight = iValid_AM_Delta & ~iRST;
                if (iValid_AM_Delta && iValid_AM_Weight) begin
                    accept  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: if (cnt_last) state_d = OUT;
            OUT:  if (valid_q && iReady_BM_Accum) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Terms are registered one stage before the add, so the sum is complete
    // one cycle after the FSM reaches OUT; valid_q tracks that extra stage.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            delta_q    <= '0;
            w_q        <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            term_q     <= '0;
            term_vld_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= (state_q == OUT) && !(valid_q && iReady_BM_Accum);
            if (accept) begin
                delta_q    <= iData_AM_Delta;
                w_q        <= iData_AM_Weight;
                cnt_q      <= '0;
                acc_q      <= '0;
                term_vld_q <= 1'b0;
            end else begin
                term_vld_q <= (state_q == CALC);
                if (state_q == CALC) begin
                    term_q <= term;
                    cnt_q  <= cnt_last ? '0 : cnt_q + CW'(1);
                end
                if (term_vld_q) begin
                    for (int i = 0; i < NP; i++) acc_q[i] <= acc_q[i] + term_q[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_backprop_accum.sv
// Scoreboard bench for backprop_accum: stimulus pushes hand-computed sums, a
// negedge monitor pops and compares on every output handshake.

module tb_backprop_accum;
    localparam int NP = 2, NC = 3, WV = 4, WO = 6;

    logic                iCLK = 1'b0;
    logic                iRST;
    logic                iValid_AM_Delta, oReady_AM_Delta;
    logic [NC*WV-1:0]    iData_AM_Delta;
    logic                iValid_AM_Weight, oReady_AM_Weight;
    logic [NP*NC*WV-1:0] iData_AM_Weight;
    logic                oValid_BM_Accum, iReady_BM_Accum;
    logic [NP*WO-1:0]    oData_BM_Accum;

    int total = 0;
    int bad   = 0;
    logic [NP*WO-1:0] exp_q[$];
    logic [NP*WO-1:0] mon_exp;
    logic [NP*WO-1:0] held;
    int lat, seen;

    backprop_accum #(.NP(NP), .NC(NC), .WV(WV)) dut (
        .iCLK             (iCLK),
        .iRST             (iRST),
        .iValid_AM_Delta  (iValid_AM_Delta),
        .oReady_AM_Delta  (oReady_AM_Delta),
        .iData_AM_Delta   (iData_AM_Delta),
        .iValid_AM_Weight (iValid_AM_Weight),
        .oReady_AM_Weight (oReady_AM_Weight),
        .iData_AM_Weight  (iData_AM_Weight),
        .oValid_BM_Accum  (oValid_BM_Accum),
        .iReady_BM_Accum  (iReady_BM_Accum),
        .oData_BM_Accum   (oData_BM_Accum)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [NC*WV-1:0] pd(input int a0, input int a1, input int a2);
        logic [NC*WV-1:0] r;
        r[0*WV +: WV] = a0[WV-1:0];
        r[1*WV +: WV] = a1[WV-1:0];
        r[2*WV +: WV] = a2[WV-1:0];
        return r;
    endfunction

    function automatic logic [NP*NC*WV-1:0] pw(input int w00, input int w01, input int w02,
                                               input int w10, input int w11, input int w12);
        logic [NP*NC*WV-1:0] r;
        r[0*WV +: WV] = w00[WV-1:0];
        r[1*WV +: WV] = w01[WV-1:0];
        r[2*WV +: WV] = w02[WV-1:0];
        r[3*WV +: WV] = w10[WV-1:0];
        r[4*WV +: WV] = w11[WV-1:0];
        r[5*WV +: WV] = w12[WV-1:0];
        return r;
    endfunction

    function automatic logic [NP*WO-1:0] ps(input int s0, input int s1);
        logic [NP*WO-1:0] r;
        r[0 +: WO]  = s0[WO-1:0];
        r[WO +: WO] = s1[WO-1:0];
        return r;
    endfunction

    // monitor: one pop per output handshake
    always @(negedge iCLK) begin
        if (!iRST && oValid_BM_Accum && iReady_BM_Accum) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got %0h want none", oData_BM_Accum);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("sum_vector", oData_BM_Accum, mon_exp);
            end
        end
    end

    task automatic issue(input logic [NC*WV-1:0] d, input logic [NP*NC*WV-1:0] w);
        int n;
        iData_AM_Delta   = d;
        iData_AM_Weight  = w;
        iValid_AM_Delta  = 1'b1;
        iValid_AM_Weight = 1'b1;
        n = 0;
        @(negedge iCLK);
        while (!(oReady_AM_Delta && oReady_AM_Weight) && n < 100) begin
            @(negedge iCLK);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL input_handshake_timeout: got no ready want ready");
        end
        @(posedge iCLK);
        #1;
        iValid_AM_Delta  = 1'b0;
        iValid_AM_Weight = 1'b0;
    endtask

    // cycles from the handshake edge until oValid is seen
    task automatic wait_valid(output int l);
        l = 0;
        while (l < 30) begin
            @(posedge iCLK);
            l++;
            @(negedge iCLK);
            if (oValid_BM_Accum) break;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge iCLK);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        iRST             = 1'b1;
        iValid_AM_Delta  = 1'b1;
        iValid_AM_Weight = 1'b1;
        iData_AM_Delta   = pd(4, 4, 4);
        iData_AM_Weight  = pw(4, 4, 4, 4, 4, 4);
        iReady_BM_Accum  = 1'b0;
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        chk("rst_valid", 64'(oValid_BM_Accum), 64'd0);
        chk("rst_data", 64'(oData_BM_Accum), 64'd0);
        chk("rst_ready_d", 64'(oReady_AM_Delta), 64'd0);
        chk("rst_ready_w", 64'(oReady_AM_Weight), 64'd0);
        @(posedge iCLK);
        #1;
        iRST             = 1'b0;
        iValid_AM_Delta  = 1'b0;
        iValid_AM_Weight = 1'b0;
        iReady_BM_Accum  = 1'b1;

        // 0.5*0.5 = 0.25 -> 2 per term
        exp_q.push_back(ps(6, 6));
        issue(pd(4, 4, 4), pw(4, 4, 4, 4, 4, 4));
        wait_valid(lat);
        chk("latency", 64'(lat), 64'd4);
        drain();

        // (-1)*(-1) saturates to 7
        exp_q.push_back(ps(21, 21));
        issue(pd(-8, -8, -8), pw(-8, -8, -8, -8, -8, -8));
        drain();

        exp_q.push_back(ps(-21, -21));
        issue(pd(-8, -8, -8), pw(7, 7, 7, 7, 7, 7));
        drain();

        // floor rounding: -1 -> -1, -12>>>3 -> -2, -7>>>3 -> -1, -16>>>3 -> -2
        exp_q.push_back(ps(-2, -3));
        issue(pd(-1, 2, 3), pw(1, 4, -4, 7, -8, 0));
        drain();

        // join: delta alone is never accepted
        iData_AM_Delta  = pd(7, 7, 7);
        iData_AM_Weight = pw(7, 7, 7, 1, 1, 1);
        iValid_AM_Delta = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge iCLK);
            chk("join_ready_d", 64'(oReady_AM_Delta), 64'd0);
        end
        chk("join_ready_w", 64'(oReady_AM_Weight), 64'd1);
        chk("join_no_output", 64'(oValid_BM_Accum), 64'd0);
        @(posedge iCLK);
        #1;
        exp_q.push_back(ps(18, 0));
        iValid_AM_Weight = 1'b1;
        @(negedge iCLK);
        chk("join_both_ready", 64'({oReady_AM_Delta, oReady_AM_Weight}), 64'd3);
        @(posedge iCLK);
        #1;
        iValid_AM_Delta  = 1'b0;
        iValid_AM_Weight = 1'b0;
        wait_valid(lat);
        chk("join_latency", 64'(lat), 64'd4);
        drain();

        // sink backpressure with the next vector already waiting
        iReady_BM_Accum = 1'b0;
        exp_q.push_back(ps(21, 21));
        issue(pd(-8, -8, -8), pw(-8, -8, -8, -8, -8, -8));
        wait_valid(lat);
        held = oData_BM_Accum;
        chk("stall_data", 64'(held), 64'(ps(21, 21)));
        @(posedge iCLK);
        #1;
        exp_q.push_back(ps(6, 6));
        iData_AM_Delta   = pd(4, 4, 4);
        iData_AM_Weight  = pw(4, 4, 4, 4, 4, 4);
        iValid_AM_Delta  = 1'b1;
        iValid_AM_Weight = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge iCLK);
            chk("stall_valid", 64'(oValid_BM_Accum), 64'd1);
            chk("stall_hold", 64'(oData_BM_Accum), 64'(held));
            chk("stall_ready", 64'({oReady_AM_Delta, oReady_AM_Weight}), 64'd0);
            @(posedge iCLK);
            #1;
        end
        iReady_BM_Accum = 1'b1;
        @(negedge iCLK);
        @(negedge iCLK);
        chk("post_hs_valid", 64'(oValid_BM_Accum), 64'd0);
        chk("post_hs_ready", 64'({oReady_AM_Delta, oReady_AM_Weight}), 64'd3);
        @(posedge iCLK);
        #1;
        iValid_AM_Delta  = 1'b0;
        iValid_AM_Weight = 1'b0;
        wait_valid(lat);
        chk("b2b_latency", 64'(lat), 64'd4);
        drain();

        // reset during CALC aborts the vector
        issue(pd(4, 4, 4), pw(4, 4, 4, 4, 4, 4));
        @(posedge iCLK);
        #1;
        iRST = 1'b1;
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        @(negedge iCLK);
        chk("abort_valid", 64'(oValid_BM_Accum), 64'd0);
        chk("abort_acc", 64'(oData_BM_Accum), 64'd0);
        seen = 0;
        repeat (8) begin
            @(negedge iCLK);
            if (oValid_BM_Accum) seen++;
        end
        chk("abort_no_output", 64'(seen), 64'd0);
        exp_q.push_back(ps(-2, -3));
        issue(pd(-1, 2, 3), pw(1, 4, -4, 7, -8, 0));
        drain();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
